// File: rtl/imm_mat_pkg.sv
// Shared opcodes, state/class encodings and split helpers for the immediate materializer.
package imm_mat_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LUI       = 7'b0110111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_ORI  = 3'b110;
  localparam logic [2:0] F3_SLLI = 3'b001;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BASE,
    ST_LOW,
    ST_SH0,
    ST_OR0,
    ST_SH1,
    ST_OR1,
    ST_SH2,
    ST_OR2
  } imm_mat_state_e;

  typedef enum logic [1:0] {SHORT, MID, LONG} imm_class_e;

  typedef enum logic [1:0] {FMT_I, FMT_U, FMT_SH} imm_fmt_e;

  // Upper 20 bits after rounding, so that the sign-extended low 12 bits add back exactly.
  function automatic logic [19:0] split_hi20(input logic [31:0] x);
    logic [31:0] s;
    s = x + 32'h800;
    return s[31:12];
  endfunction

  function automatic logic fits_s12(input logic [31:0] x);
    return (&x[31:11]) | ~(|x[31:11]);
  endfunction

endpackage

// File: rtl/imm_materializer_pack.sv
// Combinational RV64I field packer for I-type, U-type and shift-immediate instructions.
module imm_pack
  import imm_mat_pkg::*;
(
  input  imm_fmt_e    fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [19:0] imm,
  output logic [31:0] instr
);

  always_comb begin
    instr = {imm[11:0], rs1, funct3, rd, opcode};
    case (fmt)
      FMT_U:   instr = {imm, rd, opcode};
      FMT_SH:  instr = {6'b000000, imm[5:0], rs1, funct3, rd, opcode};
      default: instr = {imm[11:0], rs1, funct3, rd, opcode};
    endcase
  end

endmodule

// File: rtl/imm_materializer.sv
// Emits an RV64I instruction sequence that rebuilds a 64-bit constant in rd.
// Optional: define IMM_MAT_SKIP_ZERO_ORI_EN to drop LONG-path ORIs whose chunk is zero.
module imm_materializer
  import imm_mat_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_value,
  input  logic [4:0]      req_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_last,
  output logic            busy
);

  if (XLEN != 64) begin : g_xlen_check
    $error("imm_materializer supports XLEN=64 only");
  end

`ifdef IMM_MAT_SKIP_ZERO_ORI_EN
  localparam logic SKIP_ZERO_ORI = 1'b1;
`else
  localparam logic SKIP_ZERO_ORI = 1'b0;
`endif

  imm_mat_state_e state, next_state;
  logic [63:0]    val_q;
  logic [4:0]     rd_q;

  imm_class_e  cls;
  logic [31:0] base_x;
  logic        base_short;
  logic [19:0] u20;
  logic [11:0] l12;
  logic        need_low;
  logic        is_long;
  logic [10:0] c0, c1;
  logic [9:0]  c2;

  // Writes to x0 are latched as value 0 so the sequence collapses to a single ADDI x0,x0,0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      val_q <= '0;
      rd_q  <= '0;
    end else if (state == ST_IDLE) begin
      if (req_valid) begin
        val_q <= (req_rd == 5'd0) ? 64'd0 : req_value;
        rd_q  <= req_rd;
        state <= ST_BASE;
      end
    end else if (out_ready) begin
      state <= next_state;
    end
  end

  always_comb begin
    if (fits_s12(val_q[31:0]) && ((&val_q[63:32]) == val_q[31]) && ((|val_q[63:32]) == val_q[31]))
      cls = SHORT;
    else if (((&val_q[63:32]) == val_q[31]) && ((|val_q[63:32]) == val_q[31]))
      cls = MID;
    else
      cls = LONG;
  end

  assign is_long    = (cls == LONG);
  assign base_x     = is_long ? val_q[63:32] : val_q[31:0];
  assign base_short = fits_s12(base_x);
  assign u20        = split_hi20(base_x);
  assign l12        = base_x[11:0];
  assign need_low   = !base_short && (l12 != 12'd0);
  assign c0         = val_q[31:21];
  assign c1         = val_q[20:10];
  assign c2         = val_q[9:0];

  // Optional steps are skipped here, so the state after the current one is always emitted.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_BASE: next_state = need_low ? ST_LOW : (is_long ? ST_SH0 : ST_IDLE);
      ST_LOW:  next_state = is_long ? ST_SH0 : ST_IDLE;
      ST_SH0:  next_state = (SKIP_ZERO_ORI && c0 == 11'd0) ? ST_SH1 : ST_OR0;
      ST_OR0:  next_state = ST_SH1;
      ST_SH1:  next_state = (SKIP_ZERO_ORI && c1 == 11'd0) ? ST_SH2 : ST_OR1;
      ST_OR1:  next_state = ST_SH2;
      ST_SH2:  next_state = (SKIP_ZERO_ORI && c2 == 10'd0) ? ST_IDLE : ST_OR2;
      default: next_state = ST_IDLE;
    endcase
  end

  imm_fmt_e    p_fmt;
  logic [6:0]  p_op;
  logic [2:0]  p_f3;
  logic [4:0]  p_rs1;
  logic [19:0] p_imm;
  logic [31:0] p_instr;

  always_comb begin
    p_fmt = FMT_I;
    p_op  = OP_IMM;
    p_f3  = F3_ADDI;
    p_rs1 = rd_q;
    p_imm = '0;
    case (state)
      ST_BASE: begin
        if (base_short) begin
          p_rs1 = 5'd0;
          p_imm = {8'd0, base_x[11:0]};
        end else begin
          p_fmt = FMT_U;
          p_op  = LUI;
          p_imm = u20;
        end
      end
      ST_LOW: begin
        p_op  = OP_IMM_32;
        p_imm = {8'd0, l12};
      end
      ST_SH0, ST_SH1: begin
        p_fmt = FMT_SH;
        p_f3  = F3_SLLI;
        p_imm = 20'd11;
      end
      ST_SH2: begin
        p_fmt = FMT_SH;
        p_f3  = F3_SLLI;
        p_imm = 20'd10;
      end
      ST_OR0: begin p_f3 = F3_ORI; p_imm = {9'd0, c0}; end
      ST_OR1: begin p_f3 = F3_ORI; p_imm = {9'd0, c1}; end
      ST_OR2: begin p_f3 = F3_ORI; p_imm = {10'd0, c2}; end
      default: ;
    endcase
  end

  imm_pack u_pack (
    .fmt    (p_fmt),
    .opcode (p_op),
    .funct3 (p_f3),
    .rd     (rd_q),
    .rs1    (p_rs1),
    .imm    (p_imm),
    .instr  (p_instr)
  );

  assign busy      = (state != ST_IDLE);
  assign req_ready = (state == ST_IDLE);
  assign out_valid = busy;
  assign out_instr = busy ? p_instr : 32'h0;
  assign out_last  = busy && (next_state == ST_IDLE);

endmodule
